dma_prog_seq: RTL and testbench
===============================

DMA_PROG_SEQ -- requirements
Module: dma_prog_seq

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 16, register data and operand width.
- ADDR_W, 8, register address width.
- NUM_CH, 4, number of DMA channels (1..8).
- MEM_LIMIT, 32764, highest memory address; operands above it are peripheral.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- instr_valid, in, 1, instruction offered.
- instr_ready, out, 1, sequencer can accept an instruction.
- op_code, in, 6, instruction opcode.
- operand, in, DATA_W, address or count operand.
- ch_sel, in, max(1,clog2(NUM_CH)), target channel.
- reg_wr, out, 1, register write request to the DMA controller.
- reg_addr, out, ADDR_W, DMA register address.
- reg_data, out, DATA_W, DMA register data.
- reg_ack, in, 1, controller accepted the current write.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle pulse when a sequence completes.
- err, out, 1, one-cycle pulse for an illegal or unknown instruction.

Function
REQ-003 Register map: command=7, mode=10, mask=11, request=12. Per channel c: base=16+4c, count=17+4c, dest=18+4c. "c" below means ch_sel zero-extended.
REQ-004 FSM states are IDLE, WRITE and DONE. instr_ready=1 only in IDLE. Handshake occurs when instr_valid && instr_ready at a rising edge, and opcode, operand and ch_sel are latched at that edge.
REQ-005 Sequence list (in order) by opcode; "peripheral" means operand > MEM_LIMIT.
- 56 LOAD_COUNT: count<=operand.
- 57 SOURCE, peripheral: command<=0x0080; mask<=c; mode<=0x0008|c; request<=0x0004|c; mem_src[c]<=0.
- 57 SOURCE, memory: base<=operand; mask<=c; request<=0x0004|c; mem_src[c]<=1.
- 59 DEST, mem_src[c]=1, memory: dest<=operand; command<=0x0001; request<=0x0004|c; mem_src[c]<=0.
- 59 DEST, mem_src[c]=1, peripheral: mode<=0x0004|c; command<=0x0000; mem_src[c]<=0.
- 59 DEST, mem_src[c]=0, memory: base<=operand.
- 59 DEST, mem_src[c]=0, peripheral: illegal (IO-to-IO).
REQ-006 operand == MEM_LIMIT is memory.
REQ-007 An illegal or unknown opcode is accepted, produces no writes, pulses err in the cycle after acceptance, and the FSM stays in IDLE. mem_src is unchanged.
REQ-008 mem_src is an NUM_CH-bit register with one flag per channel. Each flag updates when its sequence's last write is acknowledged.
REQ-009 WRITE state: write k drives reg_wr=1 with stable reg_addr/reg_data until the edge where reg_ack=1. Write k+1 is presented in the next cycle. Outputs are registered.
REQ-010 Timing: first reg_wr rises the cycle after acceptance. reg_ack high in the same cycle as reg_wr completes that write.
REQ-011 After the last ack, the FSM goes to DONE for one cycle: done=1, reg_wr=0, instr_ready=0. It then returns to IDLE.
REQ-012 With continuous ack, an N-write sequence has reg_wr high for N consecutive cycles, then done. The next instruction can be accepted N+2 cycles after acceptance.
REQ-013 reg_ack outside an active reg_wr is ignored.
REQ-014 busy=1 in WRITE and DONE.
REQ-015 When reg_wr=0, reg_addr and reg_data hold their last values.

Reset
REQ-016 rst=1 immediately forces: FSM to IDLE, reg_wr=0, busy=0, done=0, err=0, reg_addr=0, reg_data=0, all mem_src bits=0, instr_ready=1 once rst deasserts.
REQ-017 Reset mid-sequence abandons the remaining writes without a done pulse. mem_src changes for the abandoned sequence are not retained.

Verification
REQ-018 LOAD_COUNT: op 56, ch 2, operand 0x0100, ack always high -> one write addr 25 data 0x0100, then done next cycle.
REQ-019 Memory-to-memory: op 57 ch 1 operand 0x0040, then op 59 ch 1 operand 0x0200 -> writes (20,0x0040),(11,1),(12,5), then (22,0x0200),(7,1),(12,5); mem_src[1] ends 0.
REQ-020 Boundary and mem-to-IO: op 57 ch 0 operand 32764 (memory, mem_src[0]=1), then op 59 ch 0 operand 32765 -> writes (10,0x0004),(7,0x0000); mem_src[0]=0.
REQ-021 Ack stall: peripheral SOURCE ch 3 with reg_ack low for 3 cycles per write -> each write is held 4 cycles with stable addr/data. Sequence is (7,0x80),(11,3),(10,0x0B),(12,7).
REQ-022 Errors: op 59 with mem_src=0 and operand 0x9000, and op 63 -> err pulses, no reg_wr, instr_ready returns high next cycle.
REQ-023 Reset mid-op: assert rst during the second write of REQ-019's SOURCE -> reg_wr drops asynchronously, no done, mem_src[1]=0.

Source files
------------

// File: rtl/dma_prog_seq.sv
// DMA programming sequencer: expands one channel-setup instruction into a short
// list of DMA controller register writes, each held until the controller acks it.
module dma_prog_seq #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int NUM_CH    = 4,
   parameter int MEM_LIMIT = 32764,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [5:0]        op_code,
   input  logic [DATA_W-1:0] operand,
   input  logic [CH_W-1:0]   ch_sel,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_data,
   input  logic              reg_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // state | meaning
   // IDLE  | waiting for an instruction, instr_ready high
   // WRITE | presenting register write idx_q of the current sequence
   // DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_e;
   typedef enum logic [2:0] {K_CNT, K_SRC_P, K_SRC_M, K_DST_MM, K_DST_MP, K_DST_B} kind_e;

   localparam logic [5:0] OP_CNT = 6'd56;
   localparam logic [5:0] OP_SRC = 6'd57;
   localparam logic [5:0] OP_DST = 6'd59;

   state_e              state_q, state_d;
   kind_e               kind_q, kind_d, kind_in;
   logic [1:0]          idx_q, idx_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [NUM_CH-1:0]   mem_src_q, mem_src_d;
   logic                reg_wr_q, reg_wr_d;
   logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0]   reg_data_q, reg_data_d;
   logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                legal_in, periph_in;

   // Only the first write of any sequence carries the operand, so it is taken
   // straight from the port at acceptance and never needs to be stored.
   function automatic logic [ADDR_W+DATA_W-1:0] wr_at(input kind_e k, input logic [1:0] i,
                                                     input logic [CH_W-1:0] c,
                                                     input logic [DATA_W-1:0] v);
      logic [ADDR_W-1:0] a_c, a;
      logic [DATA_W-1:0] d_c, d;
      a_c = ADDR_W'(c) << 2;
      d_c = DATA_W'(c);
      a   = '0;
      d   = '0;
      case (k)
         K_CNT: begin a = ADDR_W'(17) + a_c; d = v; end
         K_SRC_P: case (i)
            2'd0:    begin a = ADDR_W'(7);  d = DATA_W'(128); end
            2'd1:    begin a = ADDR_W'(11); d = d_c; end
            2'd2:    begin a = ADDR_W'(10); d = DATA_W'(8) | d_c; end
            default: begin a = ADDR_W'(12); d = DATA_W'(4) | d_c; end
         endcase
         K_SRC_M: case (i)
            2'd0:    begin a = ADDR_W'(16) + a_c; d = v; end
            2'd1:    begin a = ADDR_W'(11); d = d_c; end
            default: begin a = ADDR_W'(12); d = DATA_W'(4) | d_c; end
         endcase
         K_DST_MM: case (i)
            2'd0:    begin a = ADDR_W'(18) + a_c; d = v; end
            2'd1:    begin a = ADDR_W'(7);  d = DATA_W'(1); end
            default: begin a = ADDR_W'(12); d = DATA_W'(4) | d_c; end
         endcase
         K_DST_MP: case (i)
            2'd0:    begin a = ADDR_W'(10); d = DATA_W'(4) | d_c; end
            default: begin a = ADDR_W'(7);  d = '0; end
         endcase
         default: begin a = ADDR_W'(16) + a_c; d = v; end
      endcase
      return {a, d};
   endfunction

   function automatic logic [1:0] last_idx(input kind_e k);
      case (k)
         K_SRC_P:           return 2'd3;
         K_SRC_M, K_DST_MM: return 2'd2;
         K_DST_MP:          return 2'd1;
         default:           return 2'd0;
      endcase
   endfunction

   assign periph_in = operand > DATA_W'(MEM_LIMIT);

   always_comb begin
      kind_in  = K_CNT;
      legal_in = 1'b1;
      case (op_code)
         OP_CNT: kind_in = K_CNT;
         OP_SRC: kind_in = periph_in ? K_SRC_P : K_SRC_M;
         OP_DST: begin
            if (mem_src_q[ch_sel])  kind_in = periph_in ? K_DST_MP : K_DST_MM;
            else if (periph_in)     legal_in = 1'b0;
            else                    kind_in = K_DST_B;
         end
         default: legal_in = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      idx_d      = idx_q;
      ch_d       = ch_q;
      mem_src_d  = mem_src_q;
      reg_wr_d   = reg_wr_q;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               if (legal_in) begin
                  state_d  = ST_WRITE;
                  kind_d   = kind_in;
                  ch_d     = ch_sel;
                  idx_d    = 2'd0;
                  reg_wr_d = 1'b1;
                  busy_d   = 1'b1;
                  {reg_addr_d, reg_data_d} = wr_at(kind_in, 2'd0, ch_sel, operand);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WRITE: begin
            if (reg_ack) begin
               if (idx_q == last_idx(kind_q)) begin
                  state_d  = ST_DONE;
                  reg_wr_d = 1'b0;
                  done_d   = 1'b1;
                  case (kind_q)
                     K_SRC_P, K_DST_MM, K_DST_MP: mem_src_d[ch_q] = 1'b0;
                     K_SRC_M:                     mem_src_d[ch_q] = 1'b1;
                     default: ;
                  endcase
               end else begin
                  idx_d = 2'(idx_q + 2'd1);
                  {reg_addr_d, reg_data_d} = wr_at(kind_q, 2'(idx_q + 2'd1), ch_q, operand);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         kind_q     <= K_CNT;
         idx_q      <= '0;
         ch_q       <= '0;
         mem_src_q  <= '0;
         reg_wr_q   <= 1'b0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         idx_q      <= idx_d;
         ch_q       <= ch_d;
         mem_src_q  <= mem_src_d;
         reg_wr_q   <= reg_wr_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign reg_wr      = reg_wr_q;
   assign reg_addr    = reg_addr_q;
   assign reg_data    = reg_data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_dma_prog_seq.sv
// Directed bench for dma_prog_seq: expected register writes are queued per
// instruction and popped as the sequencer completes each write.
module tb_dma_prog_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  op_code;
   logic [15:0] operand;
   logic [1:0]  ch_sel;
   logic        reg_wr;
   logic [7:0]  reg_addr;
   logic [15:0] reg_data;
   logic        reg_ack;
   logic        busy, done, err;

   int          n_total = 0;
   int          n_fail  = 0;
   logic [23:0] exp_q[$];

   dma_prog_seq dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op_code(op_code), .operand(operand), .ch_sel(ch_sel),
      .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data), .reg_ack(reg_ack),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [15:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic issue(input string tag, input logic [5:0] op, input logic [1:0] ch, input logic [15:0] v);
      chk(tag, "ready_before", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      op_code     = op;
      ch_sel      = ch;
      operand     = v;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   // Runs from the cycle after acceptance until done, acking after 'stall' wait cycles.
   task automatic run_seq(input string tag, input int stall, input logic ack_idle, input int exp_n);
      int          cyc, nw, hold;
      logic [23:0] first, e;
      cyc = 0; nw = 0; hold = 0; first = '0;
      chk(tag, "first_wr", {31'd0, reg_wr}, 32'd1);
      while (cyc < 300 && done !== 1'b1) begin
         if (reg_wr === 1'b1) begin
            hold++;
            if (hold == 1) first = {reg_addr, reg_data};
            if (hold > stall) begin
               reg_ack = 1'b1;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
               chk(tag, "addr", {24'd0, reg_addr}, {24'd0, e[23:16]});
               chk(tag, "data", {16'd0, reg_data}, {16'd0, e[15:0]});
               if (stall > 0) chk(tag, "stable", {8'd0, reg_addr, reg_data}, {8'd0, first});
               nw++;
               hold = 0;
            end else begin
               reg_ack = 1'b0;
            end
         end else begin
            reg_ack = ack_idle;
         end
         @(negedge clk);
         cyc++;
      end
      reg_ack = ack_idle;
      chk(tag, "done", {31'd0, done}, 32'd1);
      chk(tag, "wr_in_done", {31'd0, reg_wr}, 32'd0);
      chk(tag, "ready_in_done", {31'd0, instr_ready}, 32'd0);
      chk(tag, "busy_in_done", {31'd0, busy}, 32'd1);
      chk(tag, "n_writes", nw, exp_n);
      chk(tag, "cycles", cyc, exp_n * (stall + 1));
      chk(tag, "queue_left", exp_q.size(), 0);
      @(negedge clk);
      chk(tag, "done_drop", {31'd0, done}, 32'd0);
      chk(tag, "busy_drop", {31'd0, busy}, 32'd0);
      chk(tag, "ready_back", {31'd0, instr_ready}, 32'd1);
   endtask

   task automatic run_err(input string tag, input logic [5:0] op, input logic [1:0] ch, input logic [15:0] v);
      issue(tag, op, ch, v);
      chk(tag, "err", {31'd0, err}, 32'd1);
      chk(tag, "no_wr", {31'd0, reg_wr}, 32'd0);
      chk(tag, "ready", {31'd0, instr_ready}, 32'd1);
      chk(tag, "busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk(tag, "err_drop", {31'd0, err}, 32'd0);
      chk(tag, "no_wr2", {31'd0, reg_wr}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; op_code = '0; operand = '0; ch_sel = '0; reg_ack = 1'b0;
      #1;
      chk("reset", "reg_wr", {31'd0, reg_wr}, 32'd0);
      chk("reset", "busy", {31'd0, busy}, 32'd0);
      chk("reset", "done", {31'd0, done}, 32'd0);
      chk("reset", "err", {31'd0, err}, 32'd0);
      chk("reset", "addr", {24'd0, reg_addr}, 32'd0);
      chk("reset", "data", {16'd0, reg_data}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // LOAD_COUNT with ack held high throughout, including outside writes
      reg_ack = 1'b1;
      push(8'd25, 16'h0100);
      issue("load_cnt", 6'd56, 2'd2, 16'h0100);
      run_seq("load_cnt", 0, 1'b1, 1);
      reg_ack = 1'b0;

      push(8'd20, 16'h0040); push(8'd11, 16'h0001); push(8'd12, 16'h0005);
      issue("m2m_src", 6'd57, 2'd1, 16'h0040);
      run_seq("m2m_src", 0, 1'b0, 3);
      push(8'd22, 16'h0200); push(8'd7, 16'h0001); push(8'd12, 16'h0005);
      issue("m2m_dst", 6'd59, 2'd1, 16'h0200);
      run_seq("m2m_dst", 0, 1'b0, 3);
      run_err("m2m_flag_clr", 6'd59, 2'd1, 16'h9000);

      push(8'd16, 16'd32764); push(8'd11, 16'h0000); push(8'd12, 16'h0004);
      issue("bnd_src", 6'd57, 2'd0, 16'd32764);
      run_seq("bnd_src", 0, 1'b0, 3);
      push(8'd10, 16'h0004); push(8'd7, 16'h0000);
      issue("m2io_dst", 6'd59, 2'd0, 16'd32765);
      run_seq("m2io_dst", 0, 1'b0, 2);
      run_err("io2io", 6'd59, 2'd0, 16'h9000);
      run_err("bad_op", 6'd63, 2'd0, 16'h0000);

      push(8'd7, 16'h0080); push(8'd11, 16'h0003); push(8'd10, 16'h000B); push(8'd12, 16'h0007);
      issue("stall_src", 6'd57, 2'd3, 16'h9000);
      run_seq("stall_src", 3, 1'b0, 4);
      push(8'd28, 16'h1234);
      issue("dst_base", 6'd59, 2'd3, 16'h1234);
      run_seq("dst_base", 0, 1'b0, 1);

      // Reset during the second write of a memory SOURCE on channel 1
      reg_ack = 1'b1;
      issue("rst_mid", 6'd57, 2'd1, 16'h0040);
      chk("rst_mid", "wr1_addr", {24'd0, reg_addr}, 32'd20);
      @(negedge clk);
      chk("rst_mid", "wr2_addr", {24'd0, reg_addr}, 32'd11);
      chk("rst_mid", "wr2_on", {31'd0, reg_wr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid", "wr_drop", {31'd0, reg_wr}, 32'd0);
      chk("rst_mid", "busy_drop", {31'd0, busy}, 32'd0);
      chk("rst_mid", "addr_clr", {24'd0, reg_addr}, 32'd0);
      reg_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid", "no_done", {31'd0, done}, 32'd0);
      chk("rst_mid", "ready", {31'd0, instr_ready}, 32'd1);
      // mem_src[1] cleared: DEST memory on ch1 is a plain base write
      push(8'd20, 16'h0200);
      issue("post_rst", 6'd59, 2'd1, 16'h0200);
      run_seq("post_rst", 0, 1'b0, 1);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
